// File: rtl/phy_pkg.sv
// phy_pkg: constants and FSM encoding shared by the transmit and receive ends of the two-lane PHY link.
// No ports; provides the IDLE symbol, training length, FIFO depth, word/lane widths and the link FSM states.
package phy_pkg;
    localparam logic [7:0] IDLE_SYM_DEF    = 8'hBC;
    localparam int         TRAIN_BYTES_DEF = 4;
    localparam int         FIFO_DEPTH_DEF  = 2;
    localparam int         WORD_W          = 32;
    localparam int         LANE_W          = 16;
    typedef enum logic {TRAIN, ACTIVE} phy_state_e;
endpackage

// File: rtl/phy_tx_lane_serializer_if.sv
// phy_tx_lane_serializer_if: word input handshake and serial lane outputs of the PHY transmitter.
// Signals: valid_in/Data_in/ready_out (word handshake), Data_out_1bit_0/1 (serial lanes),
// valid_out_1bit (data-bit strobe). Modport slave is the serializer, master is the word source/lane sink.
interface phy_tx_lane_serializer_if;
    import phy_pkg::*;
    logic              valid_in;
    logic [WORD_W-1:0] Data_in;
    logic              ready_out;
    logic              Data_out_1bit_0;
    logic              Data_out_1bit_1;
    logic              valid_out_1bit;
    modport master (
        output valid_in, Data_in,
        input  ready_out, Data_out_1bit_0, Data_out_1bit_1, valid_out_1bit
    );
    modport slave (
        input  valid_in, Data_in,
        output ready_out, Data_out_1bit_0, Data_out_1bit_1, valid_out_1bit
    );
endinterface

// File: rtl/phy_word_fifo.sv
// phy_word_fifo: DEPTH x 32-bit word buffer with registered full/empty flags.
// Ports: clk_32f, reset (async active-low), push/din, pop/dout (head word, valid while !empty),
// full/empty (registered), full_nxt (full as it will be after this edge, for a registered ready).
// The caller must not push when full nor pop when empty.
module phy_word_fifo
    import phy_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              full_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full_q, empty_q, empty_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        full_nxt = cnt_d == (AW+1)'(DEPTH);
        empty_d  = cnt_d == '0;
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_nxt;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset: contents are only ever read behind the empty flag.
    always_ff @(posedge clk_32f) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/phy_tx_lane_serializer.sv
// phy_tx_lane_serializer: buffers 32-bit words and serializes them MSB first over two 1-bit lanes
// (lane0 = [31:16], lane1 = [15:0]), one word per 16-cycle slot, with an IDLE training run after reset.
// Ports: clk_32f (bit clock), reset (async active-low), tx (slave modport: valid_in/Data_in/ready_out
// handshake, Data_out_1bit_0/1 serial lanes, valid_out_1bit data strobe).
module phy_tx_lane_serializer
    import phy_pkg::*;
#(
    parameter logic [7:0] IDLE_SYM    = IDLE_SYM_DEF,
    parameter int         TRAIN_BYTES = TRAIN_BYTES_DEF,
    parameter int         FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input logic                      clk_32f,
    input logic                      reset,
    phy_tx_lane_serializer_if.slave  tx
);
    localparam logic [LANE_W-1:0] IDLE_PAIR = {IDLE_SYM, IDLE_SYM};

    phy_state_e        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [LANE_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic              flag_q, flag_d;
    logic              lane0_q, lane0_d, lane1_q, lane1_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;

    logic              load, train_end, take, push, pop;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_full_nxt;

    phy_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (tx.Data_in),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    always_comb begin
        load       = bit_cnt_q == 4'd15;
        // The slot ending on this load edge completes training, so this load may already carry data.
        train_end  = state_q == TRAIN && load && int'(byte_cnt_q) + 2 >= TRAIN_BYTES;
        take       = load && (state_q == ACTIVE || train_end);
        // Registered empty: a word pushed on this same edge waits for the next slot.
        pop        = take && !fifo_empty;
        push       = tx.valid_in && ready_q && !fifo_full;
        state_d    = train_end ? ACTIVE : state_q;
        bit_cnt_d  = bit_cnt_q + 4'd1;
        byte_cnt_d = (state_q == TRAIN && load) ? byte_cnt_q + 8'd2 : byte_cnt_q;
        sh0_d      = !load ? {sh0_q[LANE_W-2:0], 1'b0} : pop ? fifo_dout[WORD_W-1:LANE_W] : IDLE_PAIR;
        sh1_d      = !load ? {sh1_q[LANE_W-2:0], 1'b0} : pop ? fifo_dout[LANE_W-1:0] : IDLE_PAIR;
        flag_d     = load ? pop : flag_q;
        // Output stage lags the shifter by one edge, so the strobe lags the slot flag likewise.
        lane0_d    = sh0_q[LANE_W-1];
        lane1_d    = sh1_q[LANE_W-1];
        valid_d    = flag_q;
        ready_d    = !fifo_full_nxt;
    end

    // Shifters reset to an IDLE pair so the training run starts on the first edge after release.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= TRAIN;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sh0_q      <= IDLE_PAIR;
            sh1_q      <= IDLE_PAIR;
            flag_q     <= 1'b0;
            lane0_q    <= 1'b0;
            lane1_q    <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            flag_q     <= flag_d;
            lane0_q    <= lane0_d;
            lane1_q    <= lane1_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign tx.ready_out       = ready_q;
    assign tx.Data_out_1bit_0 = lane0_q;
    assign tx.Data_out_1bit_1 = lane1_q;
    assign tx.valid_out_1bit  = valid_q;
endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// tb_phy_tx_lane_serializer: directed self-checking bench for the two-lane PHY transmitter.
module tb_phy_tx_lane_serializer;
    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    logic l0_log [0:511];
    logic l1_log [0:511];
    logic v_log  [0:511];

    phy_tx_lane_serializer_if bus ();

    phy_tx_lane_serializer dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .tx      (bus)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge; outputs are logged on the following falling edge, indexed by edge number.
    task automatic tick();
        @(posedge clk_32f);
        @(negedge clk_32f);
        cyc++;
        l0_log[cyc] = bus.Data_out_1bit_0;
        l1_log[cyc] = bus.Data_out_1bit_1;
        v_log[cyc]  = bus.valid_out_1bit;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // 16 logged bits starting at edge s, first bit in the MSB.
    function automatic logic [15:0] seg(input int which, input int s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[15-i] = which == 0 ? l0_log[s+i] : which == 1 ? l1_log[s+i] : v_log[s+i];
        return r;
    endfunction

    initial begin
        bus.valid_in = 1'b0;
        bus.Data_in  = '0;
        repeat (3) @(negedge clk_32f);
        chk("rst_ready", 32'(bus.ready_out), 32'd0);
        chk("rst_lane0", 32'(bus.Data_out_1bit_0), 32'd0);
        chk("rst_lane1", 32'(bus.Data_out_1bit_1), 32'd0);
        chk("rst_valid", 32'(bus.valid_out_1bit), 32'd0);
        reset = 1'b1;
        cyc   = 0;

        // 1: training run
        tick();
        chk("ready_first_edge", 32'(bus.ready_out), 32'd1);
        run_to(32);
        chk("train_l0_a", 32'(seg(0, 1)), 32'hBCBC);
        chk("train_l0_b", 32'(seg(0, 17)), 32'hBCBC);
        chk("train_l1_a", 32'(seg(1, 1)), 32'hBCBC);
        chk("train_l1_b", 32'(seg(1, 17)), 32'hBCBC);
        chk("train_v_a", 32'(seg(2, 1)), 32'h0);
        chk("train_v_b", 32'(seg(2, 17)), 32'h0);

        // 2: single word, pushed at edge 33, loaded at 48, sent on 49..64
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'hA5A5_0F0F;
        tick();
        bus.valid_in = 1'b0;
        chk("single_ready", 32'(bus.ready_out), 32'd1);
        run_to(65);
        chk("single_idle_v", 32'(seg(2, 33)), 32'h0);
        chk("single_l0", 32'(seg(0, 49)), 32'hA5A5);
        chk("single_l1", 32'(seg(1, 49)), 32'h0F0F);
        chk("single_v", 32'(seg(2, 49)), 32'hFFFF);
        chk("single_v_after", 32'(v_log[65]), 32'd0);

        // 3: three words with valid held; FIFO full after two
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'h1234_5678;
        tick();
        bus.Data_in  = 32'h9ABC_DEF0;
        tick();
        chk("b2b_full_ready", 32'(bus.ready_out), 32'd0);
        bus.Data_in  = 32'h0F1E_2D3C;
        run_to(79);
        chk("b2b_hold_ready", 32'(bus.ready_out), 32'd0);
        tick();
        chk("b2b_pop_ready", 32'(bus.ready_out), 32'd1);
        tick();
        bus.valid_in = 1'b0;
        chk("b2b_refill_ready", 32'(bus.ready_out), 32'd0);
        run_to(129);
        chk("b2b_v_before", 32'(v_log[80]), 32'd0);
        chk("b2b_w0_l0", 32'(seg(0, 81)), 32'h1234);
        chk("b2b_w0_l1", 32'(seg(1, 81)), 32'h5678);
        chk("b2b_w1_l0", 32'(seg(0, 97)), 32'h9ABC);
        chk("b2b_w1_l1", 32'(seg(1, 97)), 32'hDEF0);
        chk("b2b_w2_l0", 32'(seg(0, 113)), 32'h0F1E);
        chk("b2b_w2_l1", 32'(seg(1, 113)), 32'h2D3C);
        chk("b2b_v", {seg(2, 81), seg(2, 97)}, 32'hFFFF_FFFF);
        chk("b2b_v_last", 32'(seg(2, 113)), 32'hFFFF);
        chk("b2b_v_after", 32'(v_log[129]), 32'd0);

        // 4: word equal to IDLE pattern
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'hBCBC_BCBC;
        tick();
        bus.valid_in = 1'b0;
        run_to(161);
        chk("idleword_v_before", 32'(seg(2, 129)), 32'h0);
        chk("idleword_l0", 32'(seg(0, 145)), 32'hBCBC);
        chk("idleword_l1", 32'(seg(1, 145)), 32'hBCBC);
        chk("idleword_v", 32'(seg(2, 145)), 32'hFFFF);
        chk("idleword_v_after", 32'(v_log[161]), 32'd0);

        // 5: push on load edge 176 with FIFO empty
        run_to(175);
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'hC3C3_3C3C;
        tick();
        bus.valid_in = 1'b0;
        chk("loadpush_ready", 32'(bus.ready_out), 32'd1);
        run_to(209);
        chk("loadpush_idle_l0", 32'(seg(0, 177)), 32'hBCBC);
        chk("loadpush_idle_v", 32'(seg(2, 177)), 32'h0);
        chk("loadpush_l0", 32'(seg(0, 193)), 32'hC3C3);
        chk("loadpush_l1", 32'(seg(1, 193)), 32'h3C3C);
        chk("loadpush_v", 32'(seg(2, 193)), 32'hFFFF);

        // 6: reset mid-word (word sent on 225..240, reset after 8 bits)
        bus.valid_in = 1'b1;
        bus.Data_in  = 32'hFFFF_FFFF;
        tick();
        bus.valid_in = 1'b0;
        bus.Data_in  = 32'h7777_7777;
        tick();
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        run_to(232);
        chk("midrst_v_before", 32'(bus.valid_out_1bit), 32'd1);
        chk("midrst_l0_before", 32'(bus.Data_out_1bit_0), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_lane0", 32'(bus.Data_out_1bit_0), 32'd0);
        chk("midrst_lane1", 32'(bus.Data_out_1bit_1), 32'd0);
        chk("midrst_valid", 32'(bus.valid_out_1bit), 32'd0);
        chk("midrst_ready", 32'(bus.ready_out), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        cyc   = 0;
        run_to(49);
        chk("retrain_l0", {seg(0, 1), seg(0, 17)}, 32'hBCBC_BCBC);
        chk("retrain_l1", {seg(1, 1), seg(1, 17)}, 32'hBCBC_BCBC);
        chk("retrain_v", {seg(2, 1), seg(2, 17)}, 32'h0);
        chk("retrain_fifo_empty_v", 32'(seg(2, 33)), 32'h0);
        chk("retrain_fifo_empty_l0", 32'(seg(0, 33)), 32'hBCBC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
